// File: rtl/gate_stream_if.sv
// gate_stream_if: byte input, ciphertext and gate descriptor handshakes of the gate stream decoder.
interface gate_stream_if #(
    parameter int ID_BYTES   = 3,
    parameter int CTXT_BYTES = 16,
    parameter int N_CTXT     = 3
);
    localparam int XW = N_CTXT > 1 ? $clog2(N_CTXT) : 1;
    logic [7:0]              input_data;
    logic                    input_strobe;
    logic                    input_ready;
    logic                    abort;
    logic [1:0]              gate_type;
    logic [8*ID_BYTES-1:0]   id_1;
    logic [8*ID_BYTES-1:0]   id_2;
    logic [8*ID_BYTES-1:0]   gate_id;
    logic [8*CTXT_BYTES-1:0] ctxt;
    logic [XW-1:0]           ctxt_idx;
    logic                    ctxt_valid;
    logic                    ctxt_ready;
    logic                    gate_valid;
    logic                    gate_ready;
    logic                    err_type;
    logic                    err_overrun;
    modport master (
        output input_data, input_strobe, abort, ctxt_ready, gate_ready,
        input  input_ready, gate_type, id_1, id_2, gate_id, ctxt, ctxt_idx,
               ctxt_valid, gate_valid, err_type, err_overrun
    );
    modport slave (
        input  input_data, input_strobe, abort, ctxt_ready, gate_ready,
        output input_ready, gate_type, id_1, id_2, gate_id, ctxt, ctxt_idx,
               ctxt_valid, gate_valid, err_type, err_overrun
    );
endinterface

// File: rtl/gate_stream_decoder.sv
// gate_stream_decoder: deserializes a byte stream into garbled-gate type, IDs, ciphertexts and output ID.
module gate_stream_decoder #(
    parameter int ID_BYTES   = 3,
    parameter int CTXT_BYTES = 16,
    parameter int N_CTXT     = 3
) (
    input logic          clk,
    input logic          rst_n,
    gate_stream_if.slave bus
);
    localparam int XW   = N_CTXT > 1 ? $clog2(N_CTXT) : 1;
    localparam int MAXB = ID_BYTES > CTXT_BYTES ? ID_BYTES : CTXT_BYTES;
    localparam int NW   = $clog2(MAXB + 1);
    localparam logic [NW-1:0] ID_LAST  = NW'(ID_BYTES - 1);
    localparam logic [NW-1:0] CT_LAST  = NW'(CTXT_BYTES - 1);
    localparam logic [XW-1:0] IDX_LAST = XW'(N_CTXT - 1);
    localparam logic [1:0] AND_G = 2'd0, BUF_G = 2'd2;
    localparam logic [2:0] TYPE = 3'd0, ID1 = 3'd1, ID2 = 3'd2, CTXT = 3'd3,
                           CWAIT = 3'd4, GID = 3'd5, GWAIT = 3'd6;
    logic [2:0]    state;
    logic [NW-1:0] cnt;
    logic [NW+2:0] pos;
    logic          accept, id_done, ct_done;
    assign bus.input_ready = state != CWAIT && state != GWAIT;
    assign accept  = bus.input_strobe && bus.input_ready && !bus.abort;
    assign id_done = cnt == ID_LAST;
    assign ct_done = cnt == CT_LAST;
    assign pos     = {cnt, 3'b000};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= TYPE;
            cnt             <= '0;
            bus.gate_type   <= '0;
            bus.id_1        <= '0;
            bus.id_2        <= '0;
            bus.gate_id     <= '0;
            bus.ctxt        <= '0;
            bus.ctxt_idx    <= '0;
            bus.ctxt_valid  <= 1'b0;
            bus.gate_valid  <= 1'b0;
            bus.err_type    <= 1'b0;
            bus.err_overrun <= 1'b0;
        end else begin
            bus.err_type    <= 1'b0;
            // abort swallows a same-cycle strobe without flagging it
            bus.err_overrun <= bus.input_strobe && !bus.input_ready && !bus.abort;
            if (bus.abort) begin
                state          <= TYPE;
                cnt            <= '0;
                bus.ctxt_idx   <= '0;
                bus.ctxt_valid <= 1'b0;
                bus.gate_valid <= 1'b0;
            end else begin
                case (state)
                    TYPE: if (accept) begin
                        if (bus.input_data[1:0] == 2'd3) bus.err_type <= 1'b1;
                        else begin
                            bus.gate_type <= bus.input_data[1:0];
                            cnt           <= '0;
                            state         <= ID1;
                        end
                    end
                    ID1: if (accept) begin
                        bus.id_1[pos +: 8] <= bus.input_data;
                        cnt <= id_done ? '0 : cnt + 1'b1;
                        if (id_done) begin
                            if (bus.gate_type == BUF_G) bus.id_2 <= '0;
                            state <= bus.gate_type == BUF_G ? GID : ID2;
                        end
                    end
                    ID2: if (accept) begin
                        bus.id_2[pos +: 8] <= bus.input_data;
                        cnt <= id_done ? '0 : cnt + 1'b1;
                        if (id_done) state <= bus.gate_type == AND_G ? CTXT : GID;
                    end
                    CTXT: if (accept) begin
                        bus.ctxt[pos +: 8] <= bus.input_data;
                        cnt <= ct_done ? '0 : cnt + 1'b1;
                        if (ct_done) begin
                            bus.ctxt_valid <= 1'b1;
                            state          <= CWAIT;
                        end
                    end
                    CWAIT: if (bus.ctxt_ready) begin
                        bus.ctxt_valid <= 1'b0;
                        bus.ctxt_idx   <= bus.ctxt_idx == IDX_LAST ? '0 : bus.ctxt_idx + 1'b1;
                        state          <= bus.ctxt_idx == IDX_LAST ? GID : CTXT;
                    end
                    GID: if (accept) begin
                        bus.gate_id[pos +: 8] <= bus.input_data;
                        cnt <= id_done ? '0 : cnt + 1'b1;
                        if (id_done) begin
                            bus.gate_valid <= 1'b1;
                            state          <= GWAIT;
                        end
                    end
                    GWAIT: if (bus.gate_ready) begin
                        bus.gate_valid <= 1'b0;
                        state          <= TYPE;
                    end
                    default: state <= TYPE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gate_stream_decoder.sv
// tb_gate_stream_decoder: directed frames against a default decoder and a small-parameter decoder.
module tb_gate_stream_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    gate_stream_if ia ();
    gate_stream_if #(.ID_BYTES(2), .CTXT_BYTES(4), .N_CTXT(1)) ib ();
    gate_stream_decoder ua (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    gate_stream_decoder #(.ID_BYTES(2), .CTXT_BYTES(4), .N_CTXT(1)) ub (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
    int total = 0;
    int bad = 0;
    int n_g = 0, n_et = 0, n_eo = 0, nb_g = 0, nb_c = 0;
    logic [127:0] cx_d[$];
    int           cx_i[$];
    logic [63:0]  g_t, g_1, g_2, g_o, b_1, b_2, b_o, b_c, b_ci;
    always @(negedge clk) begin
        if (ia.ctxt_valid && ia.ctxt_ready) begin
            cx_d.push_back(ia.ctxt);
            cx_i.push_back(int'(ia.ctxt_idx));
        end
        if (ia.gate_valid && ia.gate_ready) begin
            n_g++;
            g_t = 64'(ia.gate_type); g_1 = 64'(ia.id_1); g_2 = 64'(ia.id_2); g_o = 64'(ia.gate_id);
        end
        if (ia.err_type) n_et++;
        if (ia.err_overrun) n_eo++;
        if (ib.ctxt_valid && ib.ctxt_ready) begin
            nb_c++;
            b_c = 64'(ib.ctxt); b_ci = 64'(ib.ctxt_idx);
        end
        if (ib.gate_valid && ib.gate_ready) begin
            nb_g++;
            b_1 = 64'(ib.id_1); b_2 = 64'(ib.id_2); b_o = 64'(ib.gate_id);
        end
    end
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic send(input logic [7:0] b);
        int t = 0;
        while (!ia.input_ready && t < 100) begin idle(1); t++; end
        if (t >= 100) chk("send_timeout", 128'(ia.input_ready), 128'd1);
        ia.input_data = b; ia.input_strobe = 1'b1;
        idle(1);
        ia.input_strobe = 1'b0;
    endtask
    task automatic send_b(input logic [7:0] b);
        int t = 0;
        while (!ib.input_ready && t < 100) begin idle(1); t++; end
        if (t >= 100) chk("send_b_timeout", 128'(ib.input_ready), 128'd1);
        ib.input_data = b; ib.input_strobe = 1'b1;
        idle(1);
        ib.input_strobe = 1'b0;
    endtask
    task automatic send_list(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask
    initial begin
        logic [127:0] exp0;
        int ncx;
        ia.input_data = '0; ia.input_strobe = 0; ia.abort = 0; ia.ctxt_ready = 1; ia.gate_ready = 1;
        ib.input_data = '0; ib.input_strobe = 0; ib.abort = 0; ib.ctxt_ready = 1; ib.gate_ready = 1;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("rst_ready", 128'(ia.input_ready), 128'd1);
        chk("rst_gv", 128'(ia.gate_valid), 128'd0);
        chk("rst_cv", 128'(ia.ctxt_valid), 128'd0);
        chk("rst_id1", 128'(ia.id_1), 128'd0);
        chk("rst_idx", 128'(ia.ctxt_idx), 128'd0);
        // XOR frame with ready held high
        send_list('{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
        chk("xor_gv_pre", 128'(ia.gate_valid), 128'd0);
        send(8'h99);
        chk("xor_gv", 128'(ia.gate_valid), 128'd1);
        chk("xor_bubble", 128'(ia.input_ready), 128'd0);
        idle(3);
        chk("xor_ng", 128'(n_g), 128'd1);
        chk("xor_type", 128'(g_t), 128'd1);
        chk("xor_id1", 128'(g_1), 128'h332211);
        chk("xor_id2", 128'(g_2), 128'h665544);
        chk("xor_gid", 128'(g_o), 128'h998877);
        chk("xor_hold", 128'(ia.gate_id), 128'h998877);
        // BUF frame, seven bytes
        send_list('{8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h02});
        chk("buf_gv_pre", 128'(ia.gate_valid), 128'd0);
        send(8'h03);
        chk("buf_gv", 128'(ia.gate_valid), 128'd1);
        idle(3);
        chk("buf_ng", 128'(n_g), 128'd2);
        chk("buf_type", 128'(g_t), 128'd2);
        chk("buf_id1", 128'(g_1), 128'hCCBBAA);
        chk("buf_id2", 128'(g_2), 128'd0);
        chk("buf_gid", 128'(g_o), 128'h030201);
        // AND frame with a five-cycle stall on ciphertext 1
        send_list('{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
        for (int i = 0; i < 48; i++) begin
            send(8'(i));
            if (i == 31) begin
                ia.ctxt_ready = 1'b0;
                chk("and_cv1", 128'(ia.ctxt_valid), 128'd1);
                chk("and_idx1", 128'(ia.ctxt_idx), 128'd1);
                ia.input_data = 8'h20; ia.input_strobe = 1'b1;
                idle(5);
                ia.input_strobe = 1'b0;
                chk("stall_cv", 128'(ia.ctxt_valid), 128'd1);
                chk("stall_ctxt", ia.ctxt, 128'h1F1E1D1C1B1A19181716151413121110);
                ia.ctxt_ready = 1'b1;
            end
        end
        send_list('{8'h0A, 8'h0B, 8'h0C});
        idle(3);
        exp0 = 128'h0F0E0D0C0B0A09080706050403020100;
        chk("and_ncx", 128'(cx_d.size()), 128'd3);
        chk("and_i0", 128'(cx_i[0]), 128'd0);
        chk("and_i1", 128'(cx_i[1]), 128'd1);
        chk("and_i2", 128'(cx_i[2]), 128'd2);
        chk("and_c0", cx_d[0], exp0);
        chk("and_c2", cx_d[2], 128'h2F2E2D2C2B2A29282726252423222120);
        chk("and_overrun", 128'(n_eo), 128'd5);
        chk("and_type", 128'(g_t), 128'd0);
        chk("and_id2", 128'(g_2), 128'h060504);
        chk("and_gid", 128'(g_o), 128'h0C0B0A);
        // reserved type byte, then a valid XOR frame
        send(8'h03);
        idle(2);
        chk("bad_et", 128'(n_et), 128'd1);
        chk("bad_stay", 128'(ia.input_ready), 128'd1);
        send_list('{8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90});
        idle(3);
        chk("bad_xor_type", 128'(g_t), 128'd1);
        chk("bad_xor_id1", 128'(g_1), 128'h302010);
        chk("bad_xor_gid", 128'(g_o), 128'h908070);
        chk("bad_et_once", 128'(n_et), 128'd1);
        // abort partway through an AND frame, then a BUF frame
        ncx = cx_d.size();
        send_list('{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09});
        ia.abort = 1'b1; ia.input_data = 8'h55; ia.input_strobe = 1'b1;
        idle(1);
        ia.abort = 1'b0; ia.input_strobe = 1'b0;
        chk("abort_cv", 128'(ia.ctxt_valid), 128'd0);
        chk("abort_ready", 128'(ia.input_ready), 128'd1);
        send_list('{8'h02, 8'hD1, 8'hD2, 8'hD3, 8'hE1, 8'hE2, 8'hE3});
        idle(3);
        chk("abort_buf_type", 128'(g_t), 128'd2);
        chk("abort_buf_id1", 128'(g_1), 128'hD3D2D1);
        chk("abort_buf_gid", 128'(g_o), 128'hE3E2E1);
        chk("abort_no_ctxt", 128'(cx_d.size()), 128'(ncx));
        chk("abort_overrun", 128'(n_eo), 128'd5);
        // asynchronous reset while a descriptor waits
        ia.gate_ready = 1'b0;
        send_list('{8'h02, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23});
        idle(2);
        chk("gwait_hold", 128'(ia.gate_valid), 128'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_gv", 128'(ia.gate_valid), 128'd0);
        chk("arst_ready", 128'(ia.input_ready), 128'd1);
        chk("arst_gid", 128'(ia.gate_id), 128'd0);
        idle(1);
        rst_n = 1'b1; ia.gate_ready = 1'b1;
        idle(1);
        // small-parameter instance: AND frame of 11 bytes
        send_b(8'h00);
        send_b(8'h01); send_b(8'h02); send_b(8'h03); send_b(8'h04);
        send_b(8'hA0); send_b(8'hA1); send_b(8'hA2); send_b(8'hA3);
        chk("b_cv", 128'(ib.ctxt_valid), 128'd1);
        send_b(8'h05); send_b(8'h06);
        chk("b_gv", 128'(ib.gate_valid), 128'd1);
        idle(3);
        chk("b_nc", 128'(nb_c), 128'd1);
        chk("b_ctxt", 128'(b_c), 128'hA3A2A1A0);
        chk("b_idx", 128'(b_ci), 128'd0);
        chk("b_ng", 128'(nb_g), 128'd1);
        chk("b_id1", 128'(b_1), 128'h0201);
        chk("b_id2", 128'(b_2), 128'h0403);
        chk("b_gid", 128'(b_o), 128'h0605);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gate_stream_decoder.md
# gate_stream_decoder

Parametrised byte-stream deserializer for garbled-gate definitions. It sits between the SPI byte receiver and the control unit. It accepts one byte per `input_strobe` and assembles gate type, input IDs, ciphertexts and output gate ID into separately held fields. Compared with the fixed three-byte-ID / three-ciphertext decoder, it adds configurable field sizes, separate input-ID registers, a valid/ready descriptor handshake with input backpressure, rejection of reserved gate types, overrun detection and a frame abort.

## Interface
- `ID_BYTES`, default 3: bytes per wire/gate ID (1..8).
- `CTXT_BYTES`, default 16: bytes per ciphertext (1..32).
- `N_CTXT`, default 3: ciphertexts per AND gate (1..4).
- `clk` in 1: the block's one clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `input_data` in 8: received byte.
- `input_strobe` in 1: `input_data` valid this cycle.
- `input_ready` out 1: the decoder can accept a byte this cycle.
- `abort` in 1: discard the partial frame and return to TYPE.
- `gate_type` out 2: 0 = AND, 1 = XOR, 2 = BUF.
- `id_1` out 8·ID_BYTES: first input ID.
- `id_2` out 8·ID_BYTES: second input ID; zero for BUF.
- `gate_id` out 8·ID_BYTES: output storage location.
- `ctxt` out 8·CTXT_BYTES: current ciphertext.
- `ctxt_idx` out clog2(N_CTXT) (min 1): index of `ctxt`.
- `ctxt_valid` out 1 / `ctxt_ready` in 1: ciphertext handshake.
- `gate_valid` out 1 / `gate_ready` in 1: descriptor (type, id_1, id_2, gate_id) handshake.
- `err_type` out 1: one-cycle pulse when a reserved type byte is rejected.
- `err_overrun` out 1: one-cycle pulse when a strobed byte is dropped.

## Operation
- A byte is accepted when `input_strobe && input_ready`.
- Multi-byte fields are little-endian: the first byte goes to bits [7:0].
- States: TYPE, ID1, ID2, CTXT, CWAIT, GID, GWAIT.
- **TYPE**
  - `input_data[1:0]` = 0, 1 or 2: latch `gate_type`, clear the byte counter, go to ID1.
  - Value 3: byte discarded, `err_type` pulses, stay in TYPE.
  - `input_data[7:2]` is ignored.
- **ID1**: collects ID_BYTES bytes into `id_1`. After the last byte, BUF goes to GID (`id_2` ← 0); AND/XOR go to ID2.
- **ID2**: collects ID_BYTES bytes into `id_2`. After the last byte, AND goes to CTXT; XOR goes to GID.
- **CTXT**
  - Collects CTXT_BYTES bytes into `ctxt`.
  - After the last byte: `ctxt_valid` ← 1, go to CWAIT.
- **CWAIT**
  - `input_ready` = 0.
  - On `ctxt_ready`: `ctxt_valid` ← 0.
  - If `ctxt_idx` = N_CTXT−1: go to GID, `ctxt_idx` ← 0.
  - Otherwise: `ctxt_idx` +1, back to CTXT.
- **GID**
  - Collects ID_BYTES bytes into `gate_id`.
  - After the last byte: `gate_valid` ← 1, go to GWAIT.
- **GWAIT**
  - `input_ready` = 0.
  - On `gate_ready`: `gate_valid` ← 0, go to TYPE.
- `input_ready` = 1 in TYPE, ID1, ID2, CTXT and GID; 0 in CWAIT and GWAIT.
- A strobe with `input_ready` = 0 drops the byte and pulses `err_overrun`.
- Output fields hold their values until overwritten; they stay stable while the matching valid is high.
- **abort** (any state) → TYPE. It clears the counters, `ctxt_idx`, `ctxt_valid` and `gate_valid`. A byte strobed in the same cycle is dropped without `err_overrun`.
- **Reset**: state TYPE. All outputs and counters are 0; `input_ready` = 1.

## Timing
- Field registers and state update on the clock edge that accepts the byte.
- `ctxt_valid` / `gate_valid` are high the cycle after the last byte of their field.
- A valid stays high through the cycle where ready is sampled high, then drops on the next edge. A held valid is never withdrawn except by abort or reset.
- `ready` held high continuously: one bubble cycle (`input_ready` = 0) per handshake.
- A byte can be accepted the cycle after the handshake completes.
- `err_type` / `err_overrun` are registered, one cycle wide, and appear the cycle after the offending strobe.
- Frame lengths (bytes):
  - BUF = 1 + 2·ID_BYTES
  - XOR = 1 + 3·ID_BYTES
  - AND = 1 + 3·ID_BYTES + N_CTXT·CTXT_BYTES
- Counter widths are sized for max(ID_BYTES, CTXT_BYTES). Counters never wrap inside a field; they clear at every field transition.

## Test plan
- **XOR, defaults, ready held high.** Bytes 01, 11 22 33, 44 55 66, 77 88 99 → `id_1` = 0x332211, `id_2` = 0x665544, `gate_id` = 0x998877, one `gate_valid` pulse.
- **BUF.** 02, AA BB CC, 01 02 03 → `id_2` = 0, `gate_id` = 0x030201, 7 bytes total.
- **AND, `ctxt_ready` low for 5 cycles on ctxt 1.**
  - Bytes: 00, two IDs, 48 ctxt bytes 0x00..0x2F, gate ID.
  - Required: three ctxt handshakes with `ctxt_idx` 0, 1, 2.
  - Required: ctxt 2 = 0x2F2E…20.
  - Required: bytes strobed during the stall are dropped with `err_overrun` and must be resent.
- **Bad type.** 03 then a valid XOR frame → one `err_type` pulse; the XOR frame then decodes correctly.
- **Abort.** Abort after 10 bytes of an AND frame, then send a BUF frame → BUF decodes, no stale `ctxt_valid`. Async `rst_n` low mid-GWAIT clears `gate_valid` immediately.
- **Parameters ID_BYTES = 2, CTXT_BYTES = 4, N_CTXT = 1.** AND frame of 1 + 6 + 4 bytes → decodes, single ctxt with `ctxt_idx` = 0.
